// File: rtl/datapath_mc_pkg.sv
// datapath_mc_pkg: shared definitions for the multi-cycle datapath.
// Holds the controller state encoding, opcode values, fault codes and
// ALU/compare operation selectors used by datapath_mc and its bench.
//
// Instruction word layout (instr0):
//   [31:24] opcode   [23:16] op0   [15:8] op1   [7:0] op2
// instr1 carries immediates / ALU selector / label-table fields.
package datapath_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  // Opcodes
  localparam logic [7:0] OP_LIMM16 = 8'h01;  // ireg[op0] = sext(instr1[15:0])
  localparam logic [7:0] OP_LIMM32 = 8'h02;  // ireg[op0] = sext(instr1)
  localparam logic [7:0] OP_CP     = 8'h03;  // ireg[op0] = ireg[op1]
  localparam logic [7:0] OP_ALU    = 8'h04;  // ireg[op0] = ireg[op1] <instr1[3:0]> ireg[op2]
  localparam logic [7:0] OP_CMP    = 8'h05;  // as OP_ALU, compare mode
  localparam logic [7:0] OP_PADD   = 8'h06;  // preg[op0] = preg[op1] + ireg[op2]
  localparam logic [7:0] OP_PDIF   = 8'h07;  // ireg[op0] = ofs(preg[op1]) - ofs(preg[op2])
  localparam logic [7:0] OP_PCMP   = 8'h08;  // ireg[op0] = cmp(preg[op1], preg[op2])
  localparam logic [7:0] OP_PLIMM  = 8'h09;  // preg[op0] = {instr1[31:16], instr1[15:0]}
  localparam logic [7:0] OP_LBSET  = 8'h0A;  // label[instr0[15:0]] = {typ op0[5:0], base, count}
  localparam logic [7:0] OP_LMEM   = 8'h20;  // ireg[op0] = mem[preg[op1]]
  localparam logic [7:0] OP_SMEM   = 8'h21;  // mem[preg[op1]] = ireg[op0]
  localparam logic [7:0] OP_FCLR   = 8'h3F;  // leave FAULT

  // Fault codes
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_OPCODE  = 2'd1;
  localparam logic [1:0] FC_BOUNDS  = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  // ALU operation selectors
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;

  // Compare selectors (alu_iscmp = 1)
  localparam logic [3:0] CMP_EQ = 4'h0;
  localparam logic [3:0] CMP_NE = 4'h1;
  localparam logic [3:0] CMP_LT = 4'h2;
  localparam logic [3:0] CMP_LE = 4'h3;

endpackage

// File: rtl/datapath_mc_bounds.sv
// dp_bounds: pointer bounds check and address generation.
//   i_ofs   pointer offset          i_base  label base address
//   i_count label element count     o_addr  base + ofs (wraps mod 2^OFS_W)
//   o_ok    offset lies inside the label (ofs < count)
module dp_bounds #(
  parameter int OFS_W = 16
) (
  input  logic [OFS_W-1:0] i_ofs,
  input  logic [OFS_W-1:0] i_base,
  input  logic [OFS_W-1:0] i_count,
  output logic [OFS_W-1:0] o_addr,
  output logic             o_ok
);

  always_comb begin
    o_ok   = (i_ofs < i_count);
    o_addr = i_base + i_ofs;
  end

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle execution datapath controller.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start, instr0, instr1   instruction valid + words (accepted in IDLE only)
//   busy, done              not-idle flag, one-cycle completion pulse
//   fault, fault_code       fault flag and cause (1 opcode, 2 bounds, 3 timeout)
//   alu_*                   external ALU operands/selector and result
//   ireg_*                  integer register file read/write ports
//   preg_*                  pointer register file read/write ports
//   lbt_*                   label table read (combinational) and write ports
//   mem_*                   memory request/acknowledge handshake
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int NREG        = 64,
  parameter  int LBID_W      = 12,
  parameter  int OFS_W       = 16,
  parameter  int MEM_TIMEOUT = 255,
  localparam int RIDX_W      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       instr0,
  input  logic [31:0]       instr1,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [DATA_W-1:0] alu_d0,
  output logic [DATA_W-1:0] alu_d1,
  output logic [3:0]        alu_op,
  output logic              alu_iscmp,
  input  logic [DATA_W-1:0] alu_dout,
  output logic [RIDX_W-1:0] ireg_r0,
  output logic [RIDX_W-1:0] ireg_r1,
  output logic [RIDX_W-1:0] ireg_rw,
  input  logic [DATA_W-1:0] ireg_d0,
  input  logic [DATA_W-1:0] ireg_d1,
  output logic [DATA_W-1:0] ireg_dw,
  output logic              ireg_we,
  output logic [RIDX_W-1:0] preg_p0,
  output logic [RIDX_W-1:0] preg_p1,
  output logic [RIDX_W-1:0] preg_pw,
  input  logic [LBID_W-1:0] preg_lbid0,
  input  logic [LBID_W-1:0] preg_lbid1,
  input  logic [OFS_W-1:0]  preg_ofs0,
  input  logic [OFS_W-1:0]  preg_ofs1,
  output logic [LBID_W-1:0] preg_lbidw,
  output logic [OFS_W-1:0]  preg_ofsw,
  output logic              preg_we,
  output logic [LBID_W-1:0] lbt_lbidr,
  input  logic [OFS_W-1:0]  lbt_base,
  input  logic [OFS_W-1:0]  lbt_count,
  output logic              lbt_we,
  output logic [LBID_W-1:0] lbt_lbidw,
  output logic [5:0]        lbt_typw,
  output logic [OFS_W-1:0]  lbt_basew,
  output logic [OFS_W-1:0]  lbt_countw,
  output logic              mem_req,
  output logic              mem_we,
  output logic [OFS_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state, w_next;
  logic [31:0]         r_ir0, r_ir1;
  logic [TO_W-1:0]     r_wait, w_wait_next;
  logic [1:0]          r_code, w_code_next;
  logic                r_done, w_done_next;
  logic [OFS_W-1:0]    r_addr;
  logic                r_mwe;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic                w_mem_load, w_rdata_cap;
  logic [7:0]          w_op;
  logic [RIDX_W-1:0]   w_f0, w_f1, w_f2;
  logic [OFS_W-1:0]    w_baddr;
  logic                w_bok;

  assign w_op = r_ir0[31:24];
  assign w_f0 = RIDX_W'(r_ir0[23:16]);
  assign w_f1 = RIDX_W'(r_ir0[15:8]);
  assign w_f2 = RIDX_W'(r_ir0[7:0]);

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = (r_state == ST_FAULT) ? r_code : '0;

  dp_bounds #(.OFS_W(OFS_W)) u_bounds (
    .i_ofs  (preg_ofs0),
    .i_base (lbt_base),
    .i_count(lbt_count),
    .o_addr (w_baddr),
    .o_ok   (w_bok)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ir0   <= '0;
      r_ir1   <= '0;
      r_wait  <= '0;
      r_code  <= FC_NONE;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_mwe   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_next;
      r_code  <= w_code_next;
      r_wait  <= w_wait_next;
      if (r_state == ST_IDLE && start) begin
        r_ir0 <= instr0;
        r_ir1 <= instr1;
      end
      if (w_mem_load) begin
        r_addr  <= w_baddr;
        r_mwe   <= (w_op == OP_SMEM);
        r_wdata <= ireg_d0;
      end
      if (w_rdata_cap) r_rdata <= mem_rdata;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait;
    w_code_next = r_code;
    w_done_next = 1'b0;
    w_mem_load  = 1'b0;
    w_rdata_cap = 1'b0;
    alu_d0      = '0;
    alu_d1      = '0;
    alu_op      = '0;
    alu_iscmp   = 1'b0;
    ireg_r0     = '0;
    ireg_r1     = '0;
    ireg_rw     = '0;
    ireg_dw     = '0;
    ireg_we     = 1'b0;
    preg_p0     = '0;
    preg_p1     = '0;
    preg_pw     = '0;
    preg_lbidw  = '0;
    preg_ofsw   = '0;
    preg_we     = 1'b0;
    lbt_lbidr   = '0;
    lbt_we      = 1'b0;
    lbt_lbidw   = '0;
    lbt_typw    = '0;
    lbt_basew   = '0;
    lbt_countw  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (r_state)
      ST_IDLE: if (start) w_next = ST_EXEC;

      ST_EXEC: begin
        w_next      = ST_IDLE;
        w_done_next = 1'b1;
        case (w_op)
          OP_LIMM16: begin
            ireg_rw = w_f0;
            ireg_dw = DATA_W'($signed(r_ir1[15:0]));
            ireg_we = 1'b1;
          end
          OP_LIMM32: begin
            ireg_rw = w_f0;
            ireg_dw = DATA_W'($signed(r_ir1));
            ireg_we = 1'b1;
          end
          OP_CP: begin
            ireg_r0 = w_f1;
            ireg_rw = w_f0;
            ireg_dw = ireg_d0;
            ireg_we = 1'b1;
          end
          OP_ALU, OP_CMP: begin
            ireg_r0   = w_f1;
            ireg_r1   = w_f2;
            alu_d0    = ireg_d0;
            alu_d1    = ireg_d1;
            alu_op    = r_ir1[3:0];
            alu_iscmp = (w_op == OP_CMP);
            ireg_rw   = w_f0;
            ireg_dw   = alu_dout;
            ireg_we   = 1'b1;
          end
          OP_PADD: begin
            preg_p0    = w_f1;
            ireg_r0    = w_f2;
            alu_d0     = DATA_W'(preg_ofs0);
            alu_d1     = ireg_d0;
            alu_op     = ALU_ADD;
            preg_pw    = w_f0;
            preg_lbidw = preg_lbid0;
            preg_ofsw  = OFS_W'(alu_dout);
            preg_we    = 1'b1;
          end
          OP_PDIF: begin
            preg_p0 = w_f1;
            preg_p1 = w_f2;
            alu_d0  = DATA_W'(preg_ofs0);
            alu_d1  = DATA_W'(preg_ofs1);
            alu_op  = ALU_SUB;
            ireg_rw = w_f0;
            ireg_dw = alu_dout;
            ireg_we = 1'b1;
          end
          OP_PCMP: begin
            // Label ID is part of the compared value so pointers into
            // different labels never compare equal.
            preg_p0   = w_f1;
            preg_p1   = w_f2;
            alu_d0    = DATA_W'({preg_lbid0, preg_ofs0});
            alu_d1    = DATA_W'({preg_lbid1, preg_ofs1});
            alu_op    = r_ir1[3:0];
            alu_iscmp = 1'b1;
            ireg_rw   = w_f0;
            ireg_dw   = alu_dout;
            ireg_we   = 1'b1;
          end
          OP_PLIMM: begin
            preg_pw    = w_f0;
            preg_lbidw = LBID_W'(r_ir1[31:16]);
            preg_ofsw  = OFS_W'(r_ir1[15:0]);
            preg_we    = 1'b1;
          end
          OP_LBSET: begin
            lbt_we     = 1'b1;
            lbt_lbidw  = LBID_W'(r_ir0[15:0]);
            lbt_typw   = r_ir0[21:16];
            lbt_basew  = OFS_W'(r_ir1[31:16]);
            lbt_countw = OFS_W'(r_ir1[15:0]);
          end
          OP_FCLR: ;
          OP_LMEM, OP_SMEM: begin
            preg_p0     = w_f1;
            lbt_lbidr   = preg_lbid0;
            ireg_r0     = w_f0;
            w_done_next = 1'b0;
            if (w_bok) begin
              w_next      = ST_MEM;
              w_wait_next = '0;
              w_mem_load  = 1'b1;
            end else begin
              w_next      = ST_FAULT;
              w_code_next = FC_BOUNDS;
            end
          end
          default: begin
            w_next      = ST_FAULT;
            w_code_next = FC_OPCODE;
            w_done_next = 1'b0;
          end
        endcase
      end

      ST_MEM: begin
        mem_req     = 1'b1;
        mem_we      = r_mwe;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        w_wait_next = r_wait + 1'b1;
        // Ack is tested first so an ack on the final allowed cycle wins.
        if (mem_ack) begin
          w_rdata_cap = 1'b1;
          if (w_op == OP_LMEM) begin
            w_next = ST_WB;
          end else begin
            w_next      = ST_IDLE;
            w_done_next = 1'b1;
          end
        end else if (r_wait == TO_W'(MEM_TIMEOUT - 1)) begin
          w_next      = ST_FAULT;
          w_code_next = FC_TIMEOUT;
        end
      end

      ST_WB: begin
        ireg_rw     = w_f0;
        ireg_dw     = r_rdata;
        ireg_we     = 1'b1;
        w_next      = ST_IDLE;
        w_done_next = 1'b1;
      end

      ST_FAULT: begin
        if (start && instr0[31:24] == OP_FCLR) begin
          w_next      = ST_IDLE;
          w_code_next = FC_NONE;
        end
      end

      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed self-checking bench for datapath_mc.
// Register files, label table and a small ALU are modelled here; memory
// handshake is driven step by step.
module tb_datapath_mc;
  import datapath_mc_pkg::*;

  localparam int DW = 32, NR = 64, LW = 12, OW = 16, TO = 8, RW = 6;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0]   instr0 = '0, instr1 = '0;
  logic          busy, done, fault, alu_iscmp, ireg_we, preg_we, lbt_we;
  logic [1:0]    fault_code;
  logic [DW-1:0] alu_d0, alu_d1, alu_dout, ireg_d0, ireg_d1, ireg_dw;
  logic [3:0]    alu_op;
  logic [RW-1:0] ireg_r0, ireg_r1, ireg_rw, preg_p0, preg_p1, preg_pw;
  logic [LW-1:0] preg_lbid0, preg_lbid1, preg_lbidw, lbt_lbidr, lbt_lbidw;
  logic [OW-1:0] preg_ofs0, preg_ofs1, preg_ofsw, lbt_base, lbt_count;
  logic [OW-1:0] lbt_basew, lbt_countw, mem_addr;
  logic [5:0]    lbt_typw;
  logic          mem_req, mem_we, mem_ack = 1'b0;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_ireg [NR];
  logic [LW-1:0] m_plb  [NR];
  logic [OW-1:0] m_pofs [NR];
  logic [OW-1:0] m_lbase [1 << LW];
  logic [OW-1:0] m_lcnt  [1 << LW];

  always #5 clk = ~clk;

  assign ireg_d0    = m_ireg[ireg_r0];
  assign ireg_d1    = m_ireg[ireg_r1];
  assign preg_lbid0 = m_plb[preg_p0];
  assign preg_lbid1 = m_plb[preg_p1];
  assign preg_ofs0  = m_pofs[preg_p0];
  assign preg_ofs1  = m_pofs[preg_p1];
  assign lbt_base   = m_lbase[lbt_lbidr];
  assign lbt_count  = m_lcnt[lbt_lbidr];
  assign alu_dout   = alu_iscmp ? DW'(alu_d0 == alu_d1) :
                      (alu_op == ALU_SUB) ? alu_d0 - alu_d1 : alu_d0 + alu_d1;

  always @(posedge clk) begin
    if (ireg_we) m_ireg[ireg_rw] <= ireg_dw;
    if (preg_we) begin
      m_plb[preg_pw]  <= preg_lbidw;
      m_pofs[preg_pw] <= preg_ofsw;
    end
    if (lbt_we) begin
      m_lbase[lbt_lbidw] <= lbt_basew;
      m_lcnt[lbt_lbidw]  <= lbt_countw;
    end
  end

  datapath_mc #(
    .DATA_W(DW), .NREG(NR), .LBID_W(LW), .OFS_W(OW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr0(instr0), .instr1(instr1),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
    .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_op(alu_op), .alu_iscmp(alu_iscmp),
    .alu_dout(alu_dout),
    .ireg_r0(ireg_r0), .ireg_r1(ireg_r1), .ireg_rw(ireg_rw), .ireg_d0(ireg_d0),
    .ireg_d1(ireg_d1), .ireg_dw(ireg_dw), .ireg_we(ireg_we),
    .preg_p0(preg_p0), .preg_p1(preg_p1), .preg_pw(preg_pw),
    .preg_lbid0(preg_lbid0), .preg_lbid1(preg_lbid1), .preg_ofs0(preg_ofs0),
    .preg_ofs1(preg_ofs1), .preg_lbidw(preg_lbidw), .preg_ofsw(preg_ofsw),
    .preg_we(preg_we),
    .lbt_lbidr(lbt_lbidr), .lbt_base(lbt_base), .lbt_count(lbt_count),
    .lbt_we(lbt_we), .lbt_lbidw(lbt_lbidw), .lbt_typw(lbt_typw),
    .lbt_basew(lbt_basew), .lbt_countw(lbt_countw),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one instruction for a single cycle; returns in the cycle after capture.
  task automatic issue(input logic [31:0] i0, input logic [31:0] i1);
    tick();
    start = 1'b1; instr0 = i0; instr1 = i1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_ireg[i] = '0; m_plb[i] = '0; m_pofs[i] = '0;
    end
    for (int i = 0; i < (1 << LW); i++) begin
      m_lbase[i] = '0; m_lcnt[i] = '0;
    end

    // Reset state
    #3;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_fault", 64'(fault), 0);
    chk("rst_memreq", 64'(mem_req), 0);
    tick();
    reset_n = 1'b1;

    // LIMM16 r1 = 0xFFFF sign-extends
    issue({OP_LIMM16, 8'd1, 16'h0}, 32'h0000_FFFF);
    chk("limm16_we", 64'(ireg_we), 1);
    chk("limm16_rw", 64'(ireg_rw), 1);
    chk("limm16_dw", 64'(ireg_dw), 64'hFFFF_FFFF);
    chk("limm16_busy", 64'(busy), 1);
    chk("limm16_done_early", 64'(done), 0);
    tick();
    chk("limm16_done", 64'(done), 1);
    chk("limm16_we_off", 64'(ireg_we), 0);
    chk("limm16_idle", 64'(busy), 0);
    tick();
    chk("limm16_done_pulse", 64'(done), 0);

    // LIMM16 positive, then ALU add r3 = r1 + r2
    issue({OP_LIMM16, 8'd2, 16'h0}, 32'h0000_1234);
    chk("limm16p_dw", 64'(ireg_dw), 64'h1234);
    issue({OP_ALU, 8'd3, 8'd1, 8'd2}, {28'h0, ALU_ADD});
    chk("alu_d0", 64'(alu_d0), 64'hFFFF_FFFF);
    chk("alu_dw", 64'(ireg_dw), 64'h1233);
    chk("alu_rw", 64'(ireg_rw), 3);

    // LIMM32 r5, PLIMM p2 = {5,3}, PADD p4 = p2 + r5 truncates to OFS_W
    issue({OP_LIMM32, 8'd5, 16'h0}, 32'h0001_0005);
    chk("limm32_dw", 64'(ireg_dw), 64'h0001_0005);
    issue({OP_PLIMM, 8'd2, 16'h0}, {16'd5, 16'd3});
    chk("plimm_we", 64'(preg_we), 1);
    chk("plimm_lbid", 64'(preg_lbidw), 5);
    chk("plimm_ofs", 64'(preg_ofsw), 3);
    issue({OP_PADD, 8'd4, 8'd2, 8'd5}, 32'h0);
    chk("padd_pw", 64'(preg_pw), 4);
    chk("padd_lbid", 64'(preg_lbidw), 5);
    chk("padd_ofs", 64'(preg_ofsw), 64'h0008);

    // LBSET label 5: base 0x100, count 4, type 0x2A
    issue({OP_LBSET, 2'b00, 6'h2A, 16'd5}, {16'h0100, 16'd4});
    chk("lbset_we", 64'(lbt_we), 1);
    chk("lbset_id", 64'(lbt_lbidw), 5);
    chk("lbset_typ", 64'(lbt_typw), 64'h2A);
    chk("lbset_base", 64'(lbt_basew), 64'h100);
    chk("lbset_cnt", 64'(lbt_countw), 4);

    // LMEM r7 via p2, ack on the third MEM cycle
    issue({OP_LMEM, 8'd7, 8'd2, 8'd0}, 32'h0);
    chk("lmem_lbidr", 64'(lbt_lbidr), 5);
    chk("lmem_exec_req", 64'(mem_req), 0);
    tick();
    chk("lmem_req1", 64'(mem_req), 1);
    chk("lmem_addr1", 64'(mem_addr), 64'h103);
    chk("lmem_we", 64'(mem_we), 0);
    tick();
    chk("lmem_addr2", 64'(mem_addr), 64'h103);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("lmem_req3", 64'(mem_req), 1);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("lmem_req_drop", 64'(mem_req), 0);
    chk("wb_we", 64'(ireg_we), 1);
    chk("wb_rw", 64'(ireg_rw), 7);
    chk("wb_dw", 64'(ireg_dw), 64'hDEAD_BEEF);
    chk("wb_done_early", 64'(done), 0);
    tick();
    chk("lmem_done", 64'(done), 1);

    // Bounds fault: p3 = {5,4} is one past the end of label 5
    issue({OP_PLIMM, 8'd3, 16'h0}, {16'd5, 16'd4});
    issue({OP_LMEM, 8'd7, 8'd3, 8'd0}, 32'h0);
    chk("oob_exec_req", 64'(mem_req), 0);
    tick();
    chk("oob_fault", 64'(fault), 1);
    chk("oob_code", 64'(fault_code), 2);
    chk("oob_busy", 64'(busy), 1);
    chk("oob_req", 64'(mem_req), 0);
    issue({OP_LIMM16, 8'd9, 16'h0}, 32'h1);
    chk("fault_ignores_start", 64'(fault), 1);
    chk("fault_no_we", 64'(ireg_we), 0);
    issue({OP_FCLR, 24'h0}, 32'h0);
    chk("fclr_fault", 64'(fault), 0);
    chk("fclr_code", 64'(fault_code), 0);
    chk("fclr_busy", 64'(busy), 0);
    chk("fclr_no_done", 64'(done), 0);

    // SMEM r1 via p2 with no ack: timeout after TO MEM cycles
    issue({OP_SMEM, 8'd1, 8'd2, 8'd0}, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == 1) begin
        chk("smem_we", 64'(mem_we), 1);
        chk("smem_wdata", 64'(mem_wdata), 64'hFFFF_FFFF);
        chk("smem_addr", 64'(mem_addr), 64'h103);
      end
      if (k == TO) begin
        chk("to_last_req", 64'(mem_req), 1);
        chk("to_last_nofault", 64'(fault), 0);
      end
    end
    tick();
    chk("to_fault", 64'(fault), 1);
    chk("to_code", 64'(fault_code), 3);
    chk("to_req", 64'(mem_req), 0);
    issue({OP_FCLR, 24'h0}, 32'h0);
    chk("to_fclr", 64'(busy), 0);

    // Same store, ack arrives on the last allowed MEM cycle
    issue({OP_SMEM, 8'd1, 8'd2, 8'd0}, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO) mem_ack = 1'b1;
    end
    tick();
    mem_ack = 1'b0;
    chk("edge_done", 64'(done), 1);
    chk("edge_fault", 64'(fault), 0);
    chk("edge_req", 64'(mem_req), 0);
    chk("edge_busy", 64'(busy), 0);

    // Reset asserted mid-MEM, late ack after release
    issue({OP_LMEM, 8'd7, 8'd2, 8'd0}, 32'h0);
    tick();
    tick();
    chk("mid_req", 64'(mem_req), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_req", 64'(mem_req), 0);
    chk("arst_addr", 64'(mem_addr), 0);
    chk("arst_busy", 64'(busy), 0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    reset_n = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_busy", 64'(busy), 0);
    chk("late_ack_we", 64'(ireg_we), 0);
    chk("late_ack_done", 64'(done), 0);

    // Start held through EXEC is ignored; then undefined opcode 0xEE
    tick();
    start = 1'b1; instr0 = {OP_LIMM16, 8'd4, 16'h0}; instr1 = 32'h5;
    tick();
    instr0 = {8'hEE, 24'h0};
    chk("held_dw", 64'(ireg_dw), 5);
    chk("held_rw", 64'(ireg_rw), 4);
    tick();
    start = 1'b0;
    chk("held_done", 64'(done), 1);
    chk("held_idle", 64'(busy), 0);
    issue({8'hEE, 24'h0}, 32'h0);
    chk("badop_ireg_we", 64'(ireg_we), 0);
    chk("badop_preg_we", 64'(preg_we), 0);
    chk("badop_lbt_we", 64'(lbt_we), 0);
    tick();
    chk("badop_fault", 64'(fault), 1);
    chk("badop_code", 64'(fault_code), 1);
    chk("badop_done", 64'(done), 0);
    issue({OP_FCLR, 24'h0}, 32'h0);
    chk("badop_fclr", 64'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning integer-register and ALU data width.
REQ-002 SHALL have parameter NREG, default 64, meaning the number of integer and pointer registers; index width RIDX_W = clog2(NREG).
REQ-003 SHALL have parameter LBID_W, default 12, meaning label-ID width.
REQ-004 SHALL have parameter OFS_W, default 16, meaning pointer offset, label base and label count width.
REQ-005 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of cycles to wait for mem_ack; the value must be at least 1.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have reset_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have start, input, 1 bit: instruction valid from the state controller.
REQ-010 SHALL have instr0 and instr1, input, 32 bits each: instruction word and extension word.
REQ-011 SHALL have busy, output, 1 bit (high when not IDLE) and done, output, 1 bit (one-cycle completion pulse).
REQ-012 SHALL have fault, output, 1 bit, and fault_code, output, 2 bits: 1 = bad opcode, 2 = bounds, 3 = timeout.
REQ-013 SHALL have alu_d0 and alu_d1, output, DATA_W; alu_op, output, 4; alu_iscmp, output, 1; alu_dout, input, DATA_W.
REQ-014 SHALL have ireg_r0, ireg_r1 and ireg_rw, output, RIDX_W; ireg_d0 and ireg_d1, input, DATA_W; ireg_dw, output, DATA_W; ireg_we, output, 1.
REQ-015 SHALL have preg_p0, preg_p1 and preg_pw, output, RIDX_W; preg_lbid0/1, input, LBID_W; preg_ofs0/1, input, OFS_W; preg_lbidw, output, LBID_W; preg_ofsw, output, OFS_W; preg_we, output, 1.
REQ-016 SHALL have lbt_lbidr, output, LBID_W, with combinational lbt_base and lbt_count, input, OFS_W; and lbt_we, lbt_lbidw, lbt_typw[5:0], lbt_basew and lbt_countw, output.
REQ-017 SHALL have mem_req, output, 1; mem_we, output, 1; mem_addr, output, OFS_W; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W; mem_ack, input, 1.

Function
REQ-018 SHALL implement the FSM states IDLE, EXEC, MEM, WB and FAULT.
REQ-019 In IDLE, start=1 SHALL register instr0/instr1 into IR0/IR1 and go to EXEC; start in any other state is ignored.
REQ-020 In EXEC, all existing register, ALU, compare, PADD, PDIF, PCMP*, PLIMM, LIMM16/32, CP and LBSET ops SHALL drive their register, ALU and label-table controls from IR0/IR1, assert write enables for exactly one cycle, and return to IDLE with done=1 in the following cycle (latency 2 cycles from start).
REQ-021 Immediates SHALL sign-extend to DATA_W; ALU results written to preg_ofsw SHALL truncate to OFS_W.
REQ-022 For OP_LMEM (rd = op0, p = op1) and OP_SMEM (rs = op0, p = op1), EXEC SHALL read p, set lbt_lbidr = preg_lbid0, and check preg_ofs0 < lbt_count.
REQ-023 If the bounds check passes, EXEC SHALL register mem_addr = lbt_base + preg_ofs0 (mod 2^OFS_W), mem_we = store, and mem_wdata = ireg_d0, then go to MEM; if it fails, go to FAULT with code 2.
REQ-024 In MEM, mem_req SHALL stay high with stable address and data until the cycle mem_ack=1; mem_req drops the cycle after ack.
REQ-025 On mem_ack in MEM, a load SHALL go to WB and a store SHALL go to IDLE with done.
REQ-026 WB SHALL write ireg_rw = rd and ireg_dw = captured mem_rdata with ireg_we for one cycle, then go to IDLE with done.
REQ-027 A wait counter SHALL clear on entering MEM and increment each MEM cycle; reaching MEM_TIMEOUT without ack SHALL go to FAULT with code 3 and drop mem_req.
REQ-028 An ack arriving on the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally with no fault.
REQ-029 An undefined opcode in EXEC SHALL go to FAULT with code 1 and perform no writes.
REQ-030 FAULT SHALL hold fault=1 and fault_code, keep busy=1, assert no write enables, and exit to IDLE only on start=1 with instr0 = OP_FCLR, which clears fault without a done pulse.
REQ-031 Outside their active cycle, all write enables, mem_req and done SHALL be 0 and all address and data outputs 0.

Reset
REQ-032 reset_n low SHALL force IDLE; clear IR0, IR1, the wait counter and fault_code; and drive every output to 0 asynchronously.
REQ-033 Reset mid-MEM SHALL drop mem_req immediately; the late ack after release is ignored.

Structure
REQ-034 Opcodes (including the new OP_LMEM, OP_SMEM and OP_FCLR), state encodings, fault codes and ALU op constants SHALL live in the shared definitions file.
REQ-035 The bounds/address unit SHALL be one sub-module, dp_bounds (ofs, base, count -> addr, ok).

Verification
REQ-036 Stimulus: LIMM16 r1=0xFFFF, start. Response: ireg_we one cycle with dw=0xFFFFFFFF and rw=1; done at cycle 2.
REQ-037 Stimulus: p2 lbid=5, ofs=3; label 5 base=0x100, count=4; LMEM r7; ack after 3 cycles with rdata=0xDEADBEEF. Response: mem_addr=0x103; r7=0xDEADBEEF written in WB.
REQ-038 Stimulus: same setup with ofs=4. Response: FAULT with code 2, no mem_req; then FCLR returns to IDLE.
REQ-039 Stimulus: MEM_TIMEOUT=8, SMEM with no ack. Response: fault code 3 after 8 MEM cycles; a second run with ack on cycle 8 completes with done and no fault.
REQ-040 Stimulus: reset_n pulsed low during MEM. Response: mem_req=0 asynchronously; IDLE after release.
REQ-041 Stimulus: start held high during a busy operation, then opcode 0xEE. Response: the extra start is ignored; then fault code 1.
